// File: rtl/uart_pkg.sv
// uart_pkg: address map, status-word bit positions and TX FSM state encoding
// shared by the store-mapped UART transmitter.
// Optional macro UART_PARITY_EN adds the PARITY state (11-bit frames).
package uart_pkg;

    localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_000C;
    localparam logic [31:0] TXCTRL_ADDR = 32'hFFFF_0008;

    // Status word bit positions for loads from TXCTRL
    localparam int unsigned ST_READY_BIT = 0;
    localparam int unsigned ST_BUSY_BIT  = 1;
    localparam int unsigned ST_OVF_BIT   = 2;

    // Writing this bit of WriteData to TXCTRL clears the overflow flag
    localparam int unsigned CTRL_OVF_CLR_BIT = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_PARITY_EN
        , PARITY = 3'd4
`endif
    } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: transmit byte queue with extra-MSB pointers.
// Full when pointer MSBs differ and the remaining bits match; empty when the
// pointers are equal. A push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic [7:0]  mem_q [DEPTH];
    logic        wr_en;
    logic        rd_en;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || rd_en);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; pointers wrap naturally through the extra MSB
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Byte storage; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/store_port_uart.sv
// store_port_uart: memory-mapped UART transmitter on the MEM stage.
// Stores to TXDATA queue a byte; loads from TXCTRL return
// {overflow, busy, ready}. Frames are start, 8 data bits LSB first, stop.
// Define UART_PARITY_EN to insert an even-parity bit after the data bits.
module store_port_uart
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        TxD
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    tx_state_e   state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]  bit_idx_q;
    logic [2:0]  idx_next;
    logic [7:0]  shift_q;
    logic        txd_q;
    logic        ovf_q;
    logic        ovf_d;

    logic        sel_data;
    logic        sel_ctrl;
    logic        push;
    logic        pop;
    logic        ovf_clr;
    logic        timer_done;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        busy;
    logic        unused_wdata;

    assign sel_data     = (Address == TXDATA_ADDR);
    assign sel_ctrl     = (Address == TXCTRL_ADDR);
    assign Hit          = sel_data || sel_ctrl;
    assign push         = MemWrite && sel_data;
    assign ovf_clr      = MemWrite && sel_ctrl && WriteData[CTRL_OVF_CLR_BIT];
    assign timer_done   = (timer_q == '0);
    assign idx_next     = bit_idx_q + 3'd1;
    assign busy         = (state_q != IDLE) || !fifo_empty;
    assign TxD          = txd_q;
    assign unused_wdata = ^WriteData[31:8];

    // Head byte leaves the FIFO when idle, or at the end of a stop bit so the
    // next start bit follows without an idle gap
    assign pop = !fifo_empty &&
                 ((state_q == IDLE) || ((state_q == STOP) && timer_done));

    // A new overflow wins over a same-cycle clear
    assign ovf_d = (push && fifo_full && !pop) || (ovf_q && !ovf_clr);

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .wdata_i (WriteData[7:0]),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Status word for loads from TXCTRL, zero otherwise
    always_comb begin
        ReadData = '0;
        if (MemRead && sel_ctrl) begin
            ReadData[ST_OVF_BIT]   = ovf_q;
            ReadData[ST_BUSY_BIT]  = busy;
            ReadData[ST_READY_BIT] = !fifo_full;
        end
    end

    // Sticky overflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    // Transmit FSM with bit timer and registered serial output.
    // The data index is left at 0 after wrapping 7->0, so every frame starts
    // with bit 0 without an explicit reload on START.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q <= fifo_rdata;
                        timer_q <= BIT_LAST;
                        txd_q   <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (timer_done) begin
                        timer_q <= BIT_LAST;
                        txd_q   <= shift_q[bit_idx_q];
                        state_q <= DATA;
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
                DATA: begin
                    if (timer_done) begin
                        timer_q   <= BIT_LAST;
                        bit_idx_q <= idx_next;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            txd_q   <= ^shift_q;
                            state_q <= PARITY;
`else
                            txd_q   <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            txd_q <= shift_q[idx_next];
                        end
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (timer_done) begin
                        timer_q <= BIT_LAST;
                        txd_q   <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
`endif
                STOP: begin
                    if (timer_done) begin
                        if (pop) begin
                            shift_q <= fifo_rdata;
                            timer_q <= BIT_LAST;
                            txd_q   <= 1'b0;
                            state_q <= START;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_port_uart.sv
// tb_store_port_uart: directed bench for store_port_uart with CLKS_PER_BIT=4,
// FIFO_DEPTH=4. The serial line is recorded on every falling clock edge and
// split into frames, which each scenario compares with hand-derived frames.
module tb_store_port_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    localparam logic [31:0] A_TXDATA = 32'hFFFF000C;
    localparam logic [31:0] A_TXCTRL = 32'hFFFF0008;
    localparam logic [31:0] A_OTHER  = 32'h10010008;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        MemWrite  = 1'b0;
    logic        MemRead   = 1'b0;
    logic [31:0] Address   = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        Hit;
    logic        TxD;

    int n_checks = 0;
    int n_pass   = 0;

    logic        rec_on = 1'b0;
    logic        rec_q[$];
    logic [10:0] fr_bits[$];
    int          fr_gap[$];
    bit          fr_stable[$];

    store_port_uart #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .TxD       (TxD)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rec_on) rec_q.push_back(TxD);
    end

    // Expected frame: bit 0 start, bits 1..8 data LSB first, then parity/stop
    function automatic logic [10:0] make_frame(input logic [7:0] d);
        logic [10:0] f;
        f      = '0;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_PARITY_EN
        f[9]   = ^d;
        f[10]  = 1'b1;
`else
        f[9]   = 1'b1;
`endif
        return f;
    endfunction

    // Split the recorded line into frames of FB bits x CPB samples
    task automatic decode_line();
        int          pos;
        int          gap;
        int          idx;
        logic [10:0] bits;
        bit          stable;
        pos = 0;
        gap = 0;
        fr_bits.delete();
        fr_gap.delete();
        fr_stable.delete();
        while (pos < rec_q.size()) begin
            if (rec_q[pos] !== 1'b0) begin
                gap++;
                pos++;
            end else begin
                bits   = '0;
                stable = 1'b1;
                for (int b = 0; b < FB; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        idx = pos + b * CPB + c;
                        if (idx >= rec_q.size()) stable = 1'b0;
                        else if (c == 0) bits[b] = rec_q[idx];
                        else if (rec_q[idx] !== bits[b]) stable = 1'b0;
                    end
                end
                fr_bits.push_back(bits);
                fr_gap.push_back(gap);
                fr_stable.push_back(stable);
                gap = 0;
                pos = pos + FB * CPB;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (TxD !== 1'b1) $display("FAIL reset_txd: got %b want 1", TxD); else n_pass++;
        MemRead = 1'b1; Address = A_TXCTRL; #1;
        n_checks++; if (ReadData !== 32'h1) $display("FAIL reset_status: got %h want 00000001", ReadData); else n_pass++;
        MemRead = 1'b0;
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (TxD !== 1'b1) $display("FAIL reset_release_txd: got %b want 1", TxD); else n_pass++;
    endtask

    task automatic test_single_frame();
        rec_q.delete(); rec_on = 1'b1;
        @(negedge clk); MemWrite = 1'b1; Address = A_TXDATA; WriteData = 32'h000000A5;
        @(negedge clk); MemWrite = 1'b0;
        n_checks++; if (TxD !== 1'b1) $display("FAIL latency_idle_txd: got %b want 1", TxD); else n_pass++;
        MemRead = 1'b1; Address = A_TXCTRL; #1;
        n_checks++; if (ReadData !== 32'h3) $display("FAIL queued_status: got %h want 00000003", ReadData); else n_pass++;
        MemRead = 1'b0;
        @(negedge clk);
        n_checks++; if (TxD !== 1'b0) $display("FAIL latency_start_txd: got %b want 0", TxD); else n_pass++;
        repeat (FB * CPB + 8) @(negedge clk);
        rec_on = 1'b0;
        MemRead = 1'b1; Address = A_TXCTRL; #1;
        n_checks++; if (ReadData !== 32'h1) $display("FAIL single_done_status: got %h want 00000001", ReadData); else n_pass++;
        MemRead = 1'b0;
        decode_line();
        n_checks++; if (fr_bits.size() !== 1) $display("FAIL single_nframes: got %0d want 1", fr_bits.size()); else n_pass++;
        if (fr_bits.size() >= 1) begin
            n_checks++; if (fr_bits[0] !== make_frame(8'hA5)) $display("FAIL single_bits: got %b want %b", fr_bits[0], make_frame(8'hA5)); else n_pass++;
            n_checks++; if (fr_stable[0] !== 1'b1) $display("FAIL single_bit_width: got unstable want %0d cycles per bit", CPB); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        rec_q.delete(); rec_on = 1'b1;
        @(negedge clk); MemWrite = 1'b1; Address = A_TXDATA; WriteData = 32'h00000055;
        @(negedge clk); WriteData = 32'h0000000F;
        @(negedge clk); MemWrite = 1'b0;
        repeat (2 * FB * CPB + 10) @(negedge clk);
        rec_on = 1'b0;
        decode_line();
        n_checks++; if (fr_bits.size() !== 2) $display("FAIL b2b_nframes: got %0d want 2", fr_bits.size()); else n_pass++;
        if (fr_bits.size() >= 2) begin
            n_checks++; if (fr_bits[0] !== make_frame(8'h55)) $display("FAIL b2b_bits0: got %b want %b", fr_bits[0], make_frame(8'h55)); else n_pass++;
            n_checks++; if (fr_bits[1] !== make_frame(8'h0F)) $display("FAIL b2b_bits1: got %b want %b", fr_bits[1], make_frame(8'h0F)); else n_pass++;
            n_checks++; if (fr_gap[1] !== 0) $display("FAIL b2b_gap: got %0d idle cycles want 0", fr_gap[1]); else n_pass++;
            n_checks++; if ((fr_stable[0] & fr_stable[1]) !== 1'b1) $display("FAIL b2b_bit_width: got unstable want %0d cycles per bit", CPB); else n_pass++;
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b [5];
        exp_b = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h24};
        rec_q.delete(); rec_on = 1'b1;
        @(negedge clk); MemWrite = 1'b1; Address = A_TXDATA; WriteData = 32'h00000011;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); WriteData = 32'h21 + i;
        end
        @(negedge clk); MemWrite = 1'b0;
        MemRead = 1'b1; Address = A_TXCTRL; #1;
        n_checks++; if (ReadData !== 32'h6) $display("FAIL ovf_full_status: got %h want 00000006", ReadData); else n_pass++;
        MemRead = 1'b0;
        repeat (FB * CPB - 5) @(negedge clk);
        MemRead = 1'b1; Address = A_TXCTRL; #1;
        n_checks++; if (ReadData !== 32'h6) $display("FAIL ovf_last_stop_status: got %h want 00000006", ReadData); else n_pass++;
        MemRead = 1'b0;
        @(negedge clk);
        MemRead = 1'b1; Address = A_TXCTRL; #1;
        n_checks++; if (ReadData !== 32'h7) $display("FAIL ovf_space_status: got %h want 00000007", ReadData); else n_pass++;
        MemRead = 1'b0;
        @(negedge clk); MemWrite = 1'b1; Address = A_TXCTRL; WriteData = 32'h00000004;
        @(negedge clk); MemWrite = 1'b0;
        MemRead = 1'b1; Address = A_TXCTRL; #1;
        n_checks++; if (ReadData !== 32'h3) $display("FAIL ovf_clear_status: got %h want 00000003", ReadData); else n_pass++;
        MemRead = 1'b0;
        repeat (4 * FB * CPB + 20) @(negedge clk);
        rec_on = 1'b0;
        decode_line();
        n_checks++; if (fr_bits.size() !== 5) $display("FAIL ovf_nframes: got %0d want 5", fr_bits.size()); else n_pass++;
        if (fr_bits.size() >= 5) begin
            for (int f = 0; f < 5; f++) begin
                n_checks++; if (fr_bits[f] !== make_frame(exp_b[f])) $display("FAIL ovf_bits%0d: got %b want %b", f, fr_bits[f], make_frame(exp_b[f])); else n_pass++;
            end
            n_checks++; if (fr_gap[4] !== 0) $display("FAIL ovf_gap: got %0d idle cycles want 0", fr_gap[4]); else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        @(negedge clk); MemWrite = 1'b1; Address = A_TXDATA; WriteData = 32'h000000A5;
        @(negedge clk); WriteData = 32'h0000003C;
        @(negedge clk); MemWrite = 1'b0;
        repeat (17) @(negedge clk);
        n_checks++; if (TxD !== 1'b0) $display("FAIL mid_data_bit3: got %b want 0", TxD); else n_pass++;
        #2; reset = 1'b0; #1;
        n_checks++; if (TxD !== 1'b1) $display("FAIL mid_reset_txd: got %b want 1", TxD); else n_pass++;
        MemRead = 1'b1; Address = A_TXCTRL; #1;
        n_checks++; if (ReadData !== 32'h1) $display("FAIL mid_reset_status: got %h want 00000001", ReadData); else n_pass++;
        MemRead = 1'b0;
        @(negedge clk); reset = 1'b1;
        rec_q.delete(); rec_on = 1'b1;
        @(negedge clk); MemWrite = 1'b1; Address = A_TXDATA; WriteData = 32'h000000C3;
        @(negedge clk); MemWrite = 1'b0;
        repeat (2 * FB * CPB + 10) @(negedge clk);
        rec_on = 1'b0;
        decode_line();
        n_checks++; if (fr_bits.size() !== 1) $display("FAIL post_reset_nframes: got %0d want 1", fr_bits.size()); else n_pass++;
        if (fr_bits.size() >= 1) begin
            n_checks++; if (fr_bits[0] !== make_frame(8'hC3)) $display("FAIL post_reset_bits: got %b want %b", fr_bits[0], make_frame(8'hC3)); else n_pass++;
        end
    endtask

    task automatic test_decode();
        @(negedge clk);
        MemRead = 1'b1; Address = A_TXCTRL; #1;
        n_checks++; if (Hit !== 1'b1) $display("FAIL dec_ctrl_hit: got %b want 1", Hit); else n_pass++;
        n_checks++; if (ReadData !== 32'h1) $display("FAIL dec_ctrl_data: got %h want 00000001", ReadData); else n_pass++;
        Address = A_TXDATA; #1;
        n_checks++; if (Hit !== 1'b1) $display("FAIL dec_data_hit: got %b want 1", Hit); else n_pass++;
        n_checks++; if (ReadData !== 32'h0) $display("FAIL dec_data_read: got %h want 00000000", ReadData); else n_pass++;
        Address = A_OTHER; #1;
        n_checks++; if (Hit !== 1'b0) $display("FAIL dec_other_hit: got %b want 0", Hit); else n_pass++;
        n_checks++; if (ReadData !== 32'h0) $display("FAIL dec_other_data: got %h want 00000000", ReadData); else n_pass++;
        MemRead = 1'b0; Address = A_TXCTRL; #1;
        n_checks++; if (ReadData !== 32'h0) $display("FAIL dec_noread_data: got %h want 00000000", ReadData); else n_pass++;
        rec_q.delete(); rec_on = 1'b1;
        @(negedge clk); MemWrite = 1'b1; Address = A_OTHER; WriteData = 32'h00000041;
        @(negedge clk); Address = A_TXCTRL; WriteData = 32'h000000FF;
        @(negedge clk); MemWrite = 1'b0;
        MemRead = 1'b1; Address = A_TXCTRL; #1;
        n_checks++; if (ReadData !== 32'h1) $display("FAIL dec_store_status: got %h want 00000001", ReadData); else n_pass++;
        MemRead = 1'b0;
        repeat (FB * CPB) @(negedge clk);
        rec_on = 1'b0;
        decode_line();
        n_checks++; if (fr_bits.size() !== 0) $display("FAIL dec_store_nframes: got %0d want 0", fr_bits.size()); else n_pass++;
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        rec_q.delete(); rec_on = 1'b1;
        @(negedge clk); MemWrite = 1'b1; Address = A_TXDATA; WriteData = 32'h00000007;
        @(negedge clk); MemWrite = 1'b0;
        repeat (FB * CPB + 10) @(negedge clk);
        rec_on = 1'b0;
        decode_line();
        n_checks++; if (fr_bits.size() !== 1) $display("FAIL parity_nframes: got %0d want 1", fr_bits.size()); else n_pass++;
        if (fr_bits.size() >= 1) begin
            n_checks++; if (fr_bits[0][9] !== 1'b1) $display("FAIL parity_bit: got %b want 1", fr_bits[0][9]); else n_pass++;
            n_checks++; if (fr_bits[0] !== 11'b11_00000111_0) $display("FAIL parity_frame: got %b want 11000001110", fr_bits[0]); else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_decode();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
